// File: rtl/imem_loader_pkg.sv
// Shared types and frame constants for the instruction-memory loader.
package imem_loader_pkg;

    localparam int LEN_W          = 16;
    localparam int CSUM_W         = 8;
    localparam int BYTES_PER_WORD = 4;

    typedef enum logic [2:0] {
        IDLE,
        LEN0,
        LEN1,
        DATA,
        CSUM,
        DONE,
        ERR
    } state_e;

endpackage

// File: rtl/word_packer.sv
// Collects little-endian payload bytes into words; pulses word_valid the cycle after the last lane.
module word_packer
    import imem_loader_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          clr,
    input  logic                          byte_vld,
    input  logic [7:0]                    byte_data,
    output logic                          last_lane,
    output logic                          word_valid,
    output logic [8*BYTES_PER_WORD-1:0]   word
);

    localparam int IDX_W = $clog2(BYTES_PER_WORD);

    logic [IDX_W-1:0]                byte_idx;
    logic [BYTES_PER_WORD-1:0][7:0]  lanes;

    assign last_lane = (byte_idx == IDX_W'(BYTES_PER_WORD - 1));

    // word is left untouched by clr so the write data bus keeps its last value between loads
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_idx   <= '0;
            lanes      <= '0;
            word_valid <= 1'b0;
            word       <= '0;
        end else begin
            word_valid <= 1'b0;
            if (clr) begin
                byte_idx <= '0;
                lanes    <= '0;
            end else if (byte_vld) begin
                lanes[byte_idx] <= byte_data;
                if (last_lane) begin
                    byte_idx   <= '0;
                    word_valid <= 1'b1;
                    word       <= {byte_data, lanes[BYTES_PER_WORD-2:0]};
                end else begin
                    byte_idx <= byte_idx + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Streams a length-prefixed, checksummed program image into IMEM and holds the core in
// reset until a complete image has been verified.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int          ADDR_W    = 10,
    parameter logic [31:0] BASE_ADDR = 32'h0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              s_valid,
    input  logic [7:0]        s_data,
    output logic              s_ready,
    output logic              imem_we,
    output logic [31:0]       imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_rst_n,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [LEN_W-1:0]  word_cnt
);

    localparam logic [LEN_W:0] DEPTH = (LEN_W+1)'(1) << ADDR_W;

    state_e              state, state_nxt;
    logic                accept;
    logic                start_load;
    logic [7:0]          len_lo;
    logic [LEN_W-1:0]    n_len;
    logic [LEN_W-1:0]    n_rx;
    logic [CSUM_W-1:0]   sum;
    logic                last_word;
    logic                pk_vld;
    logic                pk_last;

    assign s_ready    = busy;
    assign accept     = s_valid && s_ready;
    assign start_load = start && (state == IDLE || state == DONE || state == ERR);
    assign n_rx       = {s_data, len_lo};
    assign pk_vld     = accept && (state == DATA);
    // word_cnt has not yet counted the word whose last byte is arriving now
    assign last_word  = ({1'b0, word_cnt} + 1'b1) == {1'b0, n_len};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE, DONE, ERR: if (start) state_nxt = LEN0;
            LEN0: if (accept) state_nxt = LEN1;
            LEN1: begin
                if (accept) begin
                    if ({1'b0, n_rx} > DEPTH) state_nxt = ERR;
                    else if (n_rx == '0)      state_nxt = CSUM;
                    else                      state_nxt = DATA;
                end
            end
            DATA: if (accept && pk_last && last_word) state_nxt = CSUM;
            CSUM: if (accept) state_nxt = (s_data == sum) ? DONE : ERR;
            default: state_nxt = IDLE;
        endcase
    end

    // Status outputs are registered from the next state so core_rst_n never glitches
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            core_rst_n <= 1'b0;
            word_cnt   <= '0;
            sum        <= '0;
            len_lo     <= '0;
            n_len      <= '0;
            imem_addr  <= '0;
        end else begin
            busy       <= state_nxt inside {LEN0, LEN1, DATA, CSUM};
            done       <= (state_nxt == DONE);
            err        <= (state_nxt == ERR);
            core_rst_n <= (state_nxt == DONE);
            if (start_load) begin
                word_cnt <= '0;
                sum      <= '0;
            end else begin
                if (imem_we) word_cnt <= word_cnt + 1'b1;
                if (pk_vld)  sum      <= sum + s_data;
            end
            if (accept && state == LEN0) len_lo <= s_data;
            if (accept && state == LEN1) n_len  <= n_rx;
            if (pk_vld && pk_last)       imem_addr <= BASE_ADDR + (32'(word_cnt) << 2);
        end
    end

    word_packer u_packer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (start_load),
        .byte_vld   (pk_vld),
        .byte_data  (s_data),
        .last_lane  (pk_last),
        .word_valid (imem_we),
        .word       (imem_wdata)
    );

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: frame-position model checked every cycle plus literal frame results.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        s_valid = 1'b0;
    logic [7:0]  s_data = 8'h00;
    logic        s_ready, imem_we, core_rst_n, busy, done, err;
    logic [31:0] imem_addr, imem_wdata;
    logic [15:0] word_cnt;

    imem_loader #(.ADDR_W(10), .BASE_ADDR(32'h0)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .s_valid(s_valid), .s_data(s_data),
        .s_ready(s_ready), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .core_rst_n(core_rst_n), .busy(busy), .done(done), .err(err), .word_cnt(word_cnt)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", name, act, exp);
    endtask

    // Model: tracks position within the frame, not loader states
    localparam int DEPTH = 1024;
    bit          m_busy, m_done, m_err, m_we;
    logic [31:0] m_addr, m_wdata, m_word;
    int          m_cnt, m_pos, m_len;
    logic [7:0]  m_sum;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 0; m_done = 0; m_err = 0; m_we = 0;
            m_addr = 0; m_wdata = 0; m_word = 0;
            m_cnt = 0; m_pos = 0; m_len = 0; m_sum = 0;
        end else begin
            if (m_we) m_cnt = m_cnt + 1;
            m_we = 0;
            if (!m_busy) begin
                if (start) begin
                    m_busy = 1; m_done = 0; m_err = 0;
                    m_cnt = 0; m_pos = 0; m_sum = 0;
                end
            end else if (s_valid) begin
                if (m_pos == 0) begin
                    m_len = int'(s_data);
                end else if (m_pos == 1) begin
                    m_len = m_len + 256 * int'(s_data);
                    if (m_len > DEPTH) begin m_busy = 0; m_err = 1; end
                end else if (m_pos < 2 + 4 * m_len) begin
                    int k;
                    k = m_pos - 2;
                    m_sum = m_sum + s_data;
                    m_word[8*(k%4) +: 8] = s_data;
                    if (k % 4 == 3) begin
                        m_we = 1;
                        m_addr = 32'(4 * (k / 4));
                        m_wdata = m_word;
                    end
                end else begin
                    m_busy = 0;
                    if (s_data == m_sum) m_done = 1;
                    else m_err = 1;
                end
                m_pos++;
            end
        end
    end

    logic [31:0] wlog_addr[$];
    logic [31:0] wlog_data[$];

    always @(negedge clk) begin
        chk("s_ready", 32'(s_ready), 32'(m_busy));
        chk("busy", 32'(busy), 32'(m_busy));
        chk("done", 32'(done), 32'(m_done));
        chk("err", 32'(err), 32'(m_err));
        chk("core_rst_n", 32'(core_rst_n), 32'(m_done));
        chk("imem_we", 32'(imem_we), 32'(m_we));
        chk("imem_addr", imem_addr, m_addr);
        chk("imem_wdata", imem_wdata, m_wdata);
        chk("word_cnt", 32'(word_cnt), 32'(m_cnt));
        if (imem_we) begin
            wlog_addr.push_back(imem_addr);
            wlog_data.push_back(imem_wdata);
        end
    end

    // All driving tasks start and end 1 time unit after a rising edge
    task automatic idle(input int n);
        s_valid = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit ok;
        int n;
        s_valid = 1'b1;
        s_data  = b;
        n = 0;
        forever begin
            @(negedge clk);
            ok = s_ready;
            @(posedge clk); #1;
            if (ok) break;
            n++;
            if (n > 20) begin
                $display("FAIL send_timeout: got s_ready=0 for %0d cycles want 1", n);
                n_chk++;
                break;
            end
        end
        s_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] f[$], input bit gaps);
        foreach (f[i]) begin
            if (gaps) begin
                idle($urandom_range(0, 3));
                if ($urandom_range(0, 2) == 0) pulse_start();
            end
            send_byte(f[i]);
        end
    endtask

    task automatic chk_t1_writes(input string tag);
        chk({tag, "_nwr"}, 32'(wlog_addr.size()), 32'd2);
        if (wlog_addr.size() == 2) begin
            chk({tag, "_a0"}, wlog_addr[0], 32'h0);
            chk({tag, "_d0"}, wlog_data[0], 32'h00500093);
            chk({tag, "_a1"}, wlog_addr[1], 32'h4);
            chk({tag, "_d1"}, wlog_data[1], 32'h00100113);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_s_ready"}, 32'(s_ready), 0);
        chk({tag, "_imem_we"}, 32'(imem_we), 0);
        chk({tag, "_imem_addr"}, imem_addr, 0);
        chk({tag, "_imem_wdata"}, imem_wdata, 0);
        chk({tag, "_core_rst_n"}, 32'(core_rst_n), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_err"}, 32'(err), 0);
        chk({tag, "_word_cnt"}, 32'(word_cnt), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] t1[$];
        logic [7:0] t2[$];
        logic [7:0] t3[$];
        logic [7:0] t4[$];
        t1 = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'h10, 8'h00, 8'h07};
        t2 = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'h10, 8'h00, 8'h08};
        t3 = '{8'h00, 8'h00, 8'h00};
        t4 = '{8'h01, 8'h04};

        repeat (2) @(posedge clk); #1;
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        idle(2);

        // 1: two-word image
        wlog_addr.delete(); wlog_data.delete();
        pulse_start();
        send_frame(t1, 1'b0);
        idle(2);
        chk_t1_writes("t1");
        chk("t1_done", 32'(done), 1);
        chk("t1_err", 32'(err), 0);
        chk("t1_core_rst_n", 32'(core_rst_n), 1);
        chk("t1_word_cnt", 32'(word_cnt), 2);

        // 2: bad checksum, then recovery
        wlog_addr.delete(); wlog_data.delete();
        pulse_start();
        chk("t2_core_rst_drop", 32'(core_rst_n), 0);
        send_frame(t2, 1'b0);
        idle(2);
        chk_t1_writes("t2");
        chk("t2_err", 32'(err), 1);
        chk("t2_done", 32'(done), 0);
        chk("t2_core_rst_n", 32'(core_rst_n), 0);
        wlog_addr.delete(); wlog_data.delete();
        pulse_start();
        send_frame(t1, 1'b0);
        idle(2);
        chk_t1_writes("t2r");
        chk("t2r_done", 32'(done), 1);

        // 3: empty image
        wlog_addr.delete(); wlog_data.delete();
        pulse_start();
        send_frame(t3, 1'b0);
        idle(2);
        chk("t3_nwr", 32'(wlog_addr.size()), 0);
        chk("t3_done", 32'(done), 1);
        chk("t3_word_cnt", 32'(word_cnt), 0);

        // 4: oversize length
        wlog_addr.delete(); wlog_data.delete();
        pulse_start();
        send_frame(t4, 1'b0);
        chk("t4_err", 32'(err), 1);
        chk("t4_s_ready", 32'(s_ready), 0);
        idle(3);
        chk("t4_nwr", 32'(wlog_addr.size()), 0);
        chk("t4_err_hold", 32'(err), 1);

        // 5: stalls and ignored starts mid-load
        wlog_addr.delete(); wlog_data.delete();
        pulse_start();
        send_frame(t1, 1'b1);
        idle(2);
        chk_t1_writes("t5");
        chk("t5_done", 32'(done), 1);
        chk("t5_word_cnt", 32'(word_cnt), 2);

        // 6: reset after five payload bytes, then a clean load
        pulse_start();
        for (int i = 0; i < 7; i++) send_byte(t1[i]);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("t6");
        idle(2);
        rst_n = 1'b1;
        idle(1);
        wlog_addr.delete(); wlog_data.delete();
        pulse_start();
        send_frame(t1, 1'b0);
        idle(2);
        chk_t1_writes("t6r");
        chk("t6r_done", 32'(done), 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
